// File: rtl/gpu_cache_fill_sched.sv
// Tex$/Clut$ line-fill scheduler: round-robin arbitration onto one shared VRAM burst-read port.
// Define GPU_FILL_PERF_EN to add saturating fill/wait performance counters.
module gpu_cache_fill_sched #(
  parameter int unsigned TEX_BEATS  = 2,
  parameter int unsigned CLUT_BEATS = 8
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_texFillReq,
  input  logic [16:0] i_texFillAdr,
  input  logic        i_clutFillReq,
  input  logic [14:0] i_clutFillAdr,
  output logic        o_memCmdValid,
  output logic [17:0] o_memCmdAdr,
  output logic [3:0]  o_memCmdBeats,
  input  logic        i_memCmdAck,
  input  logic        i_memDataValid,
  input  logic [31:0] i_memData,
  output logic        o_texWr,
  output logic        o_clutWr,
  output logic [2:0]  o_wrIdx,
  output logic [31:0] o_wrData,
  output logic        o_texFillDone,
  output logic        o_clutFillDone,
  output logic        o_busy
`ifdef GPU_FILL_PERF_EN
  ,
  output logic [15:0] o_texFillCnt,
  output logic [15:0] o_clutFillCnt,
  output logic [15:0] o_waitCnt
`endif
);

  // Beat index is 3 bits wide, so CLUT_BEATS must not exceed 8.
  localparam logic [3:0] TexBeats  = 4'(TEX_BEATS);
  localparam logic [3:0] ClutBeats = 4'(CLUT_BEATS);

  typedef enum logic [1:0] {StIdle, StCmd, StData, StDone} state_e;

  state_e      r_state;
  logic        r_owner_tex;
  logic        r_last_tex;
  logic        r_cool_tex;
  logic        r_cool_clut;
  logic [17:0] r_adr;
  logic [3:0]  r_beats;
  logic [3:0]  r_beat_cnt;

  logic w_elig_tex;
  logic w_elig_clut;
  logic w_grant;
  logic w_grant_tex;
  logic w_beat;
  logic w_last_beat;

  // A cooldown masks the just-served cache's still-high request for one cycle.
  assign w_elig_tex  = i_texFillReq & ~r_cool_tex;
  assign w_elig_clut = i_clutFillReq & ~r_cool_clut;
  assign w_grant     = (r_state == StIdle) & (w_elig_tex | w_elig_clut);
  assign w_grant_tex = w_elig_tex & (~w_elig_clut | ~r_last_tex);
  assign w_beat      = (r_state == StData) & i_memDataValid;
  assign w_last_beat = w_beat & (r_beat_cnt == (r_beats - 4'd1));

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_owner_tex <= 1'b0;
      r_last_tex  <= 1'b0;
      r_cool_tex  <= 1'b0;
      r_cool_clut <= 1'b0;
      r_adr       <= '0;
      r_beats     <= '0;
      r_beat_cnt  <= '0;
    end else begin
      r_cool_tex  <= 1'b0;
      r_cool_clut <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_grant) begin
            r_owner_tex <= w_grant_tex;
            r_adr       <= w_grant_tex ? {i_texFillAdr, 1'b0} : {i_clutFillAdr, 3'b000};
            r_beats     <= w_grant_tex ? TexBeats : ClutBeats;
            r_state     <= StCmd;
          end
        end
        StCmd: begin
          if (i_memCmdAck) begin
            r_beat_cnt <= '0;
            r_state    <= StData;
          end
        end
        StData: begin
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 4'd1;
            if (w_last_beat) r_state <= StDone;
          end
        end
        StDone: begin
          r_last_tex  <= r_owner_tex;
          r_cool_tex  <= r_owner_tex;
          r_cool_clut <= ~r_owner_tex;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_memCmdValid  = (r_state == StCmd);
  assign o_memCmdAdr    = o_memCmdValid ? r_adr : '0;
  assign o_memCmdBeats  = o_memCmdValid ? r_beats : '0;
  assign o_texWr        = w_beat & r_owner_tex;
  assign o_clutWr       = w_beat & ~r_owner_tex;
  assign o_wrIdx        = w_beat ? r_beat_cnt[2:0] : '0;
  assign o_wrData       = w_beat ? i_memData : '0;
  assign o_texFillDone  = (r_state == StDone) & r_owner_tex;
  assign o_clutFillDone = (r_state == StDone) & ~r_owner_tex;
  assign o_busy         = (r_state != StIdle);

`ifdef GPU_FILL_PERF_EN
  logic [15:0] r_tex_cnt;
  logic [15:0] r_clut_cnt;
  logic [15:0] r_wait_cnt;
  logic        w_srv_tex;
  logic        w_srv_clut;
  logic        w_wait;

  // A request counts as serviced while it owns the fill or is being granted this cycle.
  assign w_srv_tex  = (r_state == StIdle) ? (w_grant & w_grant_tex)  : r_owner_tex;
  assign w_srv_clut = (r_state == StIdle) ? (w_grant & ~w_grant_tex) : ~r_owner_tex;
  assign w_wait     = (w_elig_tex & ~w_srv_tex) | (w_elig_clut & ~w_srv_clut);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_tex_cnt  <= '0;
      r_clut_cnt <= '0;
      r_wait_cnt <= '0;
    end else begin
      if (o_texFillDone && (r_tex_cnt != 16'hFFFF)) r_tex_cnt <= r_tex_cnt + 16'd1;
      if (o_clutFillDone && (r_clut_cnt != 16'hFFFF)) r_clut_cnt <= r_clut_cnt + 16'd1;
      if (w_wait && (r_wait_cnt != 16'hFFFF)) r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  assign o_texFillCnt  = r_tex_cnt;
  assign o_clutFillCnt = r_clut_cnt;
  assign o_waitCnt     = r_wait_cnt;
`endif

endmodule
